// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment types and glyph table for the seven-segment driver
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Active-low, bit0 = a ... bit6 = g, indexed by the 4-bit code.
  localparam seg_t SEG_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational hex code to active-low seven-segment pattern
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_code,
  output seg_t       o_seg
);

  assign o_seg = SEG_GLYPH[i_code];

endmodule

// File: rtl/seg_mux_driver.sv
// rtl/seg_mux_driver.sv - time-multiplexed common-anode seven-segment driver with tear-free latching
// Blink support is built only when SEG_BLINK_EN is defined.
module seg_mux_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    load,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW    = $clog2(CLK_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PW-1:0]    TC_VAL   = PW'(CLK_DIV - 1);

  logic [PW-1:0]           r_presc;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_digits, r_dsp_digits;
  logic [NUM_DIGITS-1:0]   r_sh_dp, r_dsp_dp, r_sh_blank, r_dsp_blank;
  logic [NUM_DIGITS-1:0]   r_an;
  seg_t                    r_seg;
  logic                    r_dp, r_frame_done;

  logic                  w_tc, w_wrap, w_dark, w_dp_req, w_blank_sel;
  logic [3:0]            w_code;
  logic [NUM_DIGITS-1:0] w_an;
  seg_t                  w_glyph;

  assign w_tc   = (r_presc == TC_VAL);
  assign w_wrap = w_tc && (r_idx == LAST_IDX);

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [NUM_DIGITS-1:0] r_sh_blink, r_dsp_blink;
  logic [FW-1:0]         r_frame_cnt;
  logic                  r_blink_phase;

  // Phase only moves on the wrap edge, so a frame is never half-blinked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_blink    <= '0;
      r_dsp_blink   <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      if (load) r_sh_blink <= blink_in;
      if (w_wrap) begin
        r_dsp_blink <= r_sh_blink;
        if (r_frame_cnt == FRAME_LAST) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + FW'(1);
        end
      end
    end
  end
`else
  logic w_unused_blink;
  assign w_unused_blink = (^blink_in) ^ (BLINK_FRAMES > 0);
`endif

  always_comb begin
    w_code      = 4'h0;
    w_dp_req    = 1'b0;
    w_blank_sel = 1'b1;
    w_dark      = 1'b1;
    w_an        = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_code      = r_dsp_digits[i*4 +: 4];
        w_dp_req    = r_dsp_dp[i];
        w_blank_sel = r_dsp_blank[i];
        w_an[i]     = 1'b0;
`ifdef SEG_BLINK_EN
        w_dark      = w_blank_sel | (r_blink_phase & r_dsp_blink[i]);
`else
        w_dark      = w_blank_sel;
`endif
      end
    end
  end

  seg_decode u_decode (
    .i_code (w_code),
    .o_seg  (w_glyph)
  );

  // Display set is refreshed on the same edge the index returns to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_sh_digits  <= '0;
      r_sh_dp      <= '0;
      r_sh_blank   <= '1;
      r_dsp_digits <= '0;
      r_dsp_dp     <= '0;
      r_dsp_blank  <= '1;
      r_an         <= '1;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      if (w_tc) begin
        r_presc <= '0;
        r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      if (load) begin
        r_sh_digits <= digits_in;
        r_sh_dp     <= dp_in;
        r_sh_blank  <= blank_in;
      end
      if (w_wrap) begin
        r_dsp_digits <= r_sh_digits;
        r_dsp_dp     <= r_sh_dp;
        r_dsp_blank  <= r_sh_blank;
      end
      r_an         <= w_an;
      r_seg        <= w_dark ? SEG_BLANK : w_glyph;
      r_dp         <= ~(w_dp_req & ~w_dark);
      r_frame_done <= w_wrap;
    end
  end

  assign seg_out    = r_seg;
  assign dp_out     = r_dp;
  assign an_out     = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_mux_driver.sv
// tb/tb_seg_mux_driver.sv - directed self-checking bench for seg_mux_driver (4 digits, CLK_DIV=4)
module tb_seg_mux_driver;

`ifdef SEG_BLINK_EN
  localparam bit BLINK_BUILT = 1'b1;
`else
  localparam bit BLINK_BUILT = 1'b0;
`endif

  localparam logic [6:0] G_DARK = 7'b1111111;
  localparam logic [6:0] G_0 = 7'b1000000, G_1 = 7'b1111001, G_2 = 7'b0100100;
  localparam logic [6:0] G_3 = 7'b0110000, G_4 = 7'b0011001, G_5 = 7'b0010010;
  localparam logic [6:0] G_8 = 7'b0000000, G_A = 7'b0001000, G_B = 7'b0000011;
  localparam logic [6:0] G_C = 7'b1000110, G_F = 7'b0001110;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blank_in, blink_in;
  logic        load;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  seg_mux_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .blink_in   (blink_in),
    .load       (load),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_digit(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    check_val({tag, ".an"}, 32'(an_out), 32'(an));
    check_val({tag, ".seg"}, 32'(seg_out), 32'(seg));
    check_val({tag, ".dp"}, 32'(dp_out), 32'(dp));
  endtask

  task automatic wait_fd(input string tag);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (!frame_done && n < 40);
    check_val({tag, ".frame_done"}, 32'(frame_done), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl, input logic [3:0] bk);
    digits_in = d;
    dp_in     = dp;
    blank_in  = bl;
    blink_in  = bk;
    load      = 1'b1;
    tick(1);
    load      = 1'b0;
  endtask

  initial begin
    logic [5:0] vis_pat;
    rst = 1'b1; load = 1'b0;
    digits_in = '0; dp_in = '0; blank_in = '0; blink_in = '0;
    tick(2);
    check_digit("reset", 4'b1111, G_DARK, 1'b1);
    check_val("reset.frame_done", 32'(frame_done), 32'd0);

    // Free scan with nothing loaded: every slot dark, anode still walks.
    rst = 1'b0;
    tick(1);  check_digit("scan0", 4'b1110, G_DARK, 1'b1);
    tick(4);  check_digit("scan1", 4'b1101, G_DARK, 1'b1);
    tick(4);  check_digit("scan2", 4'b1011, G_DARK, 1'b1);
    tick(4);  check_digit("scan3", 4'b0111, G_DARK, 1'b1);
    tick(2);  check_val("fd_before", 32'(frame_done), 32'd0);
    tick(1);  check_val("fd_at16", 32'(frame_done), 32'd1);
    tick(1);  check_val("fd_after", 32'(frame_done), 32'd0);
    check_val("an_wrap", 32'(an_out), 32'(4'b1110));

    do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
    wait_fd("ld1234");
    check_digit("ld1234.old", 4'b0111, G_DARK, 1'b1);
    tick(1);  check_digit("ld1234.d0", 4'b1110, G_4, 1'b1);
    tick(4);  check_digit("ld1234.d1", 4'b1101, G_3, 1'b1);
    tick(8);  check_digit("ld1234.d3", 4'b0111, G_1, 1'b1);

    // Mid-frame load must not tear the frame in progress.
    wait_fd("mid.sync");
    tick(6);
    do_load(16'h0000, 4'b0000, 4'b0000, 4'b0000);
    tick(2);  check_digit("mid.d2old", 4'b1011, G_2, 1'b1);
    tick(4);  check_digit("mid.d3old", 4'b0111, G_1, 1'b1);
    wait_fd("mid.wrap");
    tick(1);  check_digit("mid.d0new", 4'b1110, G_0, 1'b1);
    tick(12); check_digit("mid.d3new", 4'b0111, G_0, 1'b1);

    do_load(16'hABCF, 4'b0100, 4'b0000, 4'b0000);
    wait_fd("hex.wrap");
    tick(1);  check_digit("hex.d0", 4'b1110, G_F, 1'b1);
    tick(4);  check_digit("hex.d1", 4'b1101, G_C, 1'b1);
    tick(4);  check_digit("hex.d2", 4'b1011, G_B, 1'b0);
    tick(4);  check_digit("hex.d3", 4'b0111, G_A, 1'b1);

    do_load(16'hABCF, 4'b0100, 4'b0001, 4'b0000);
    wait_fd("blank.wrap");
    tick(1);  check_digit("blank.d0", 4'b1110, G_DARK, 1'b1);
    tick(4);  check_digit("blank.d1", 4'b1101, G_C, 1'b1);

    // Load on the wrap cycle itself lands one frame later.
    tick(10);
    digits_in = 16'h5555; dp_in = 4'b0000; blank_in = 4'b0000; load = 1'b1;
    tick(1);
    load = 1'b0;
    check_val("wrapld.fd", 32'(frame_done), 32'd1);
    tick(1);  check_digit("wrapld.d0old", 4'b1110, G_DARK, 1'b1);
    wait_fd("wrapld.next");
    tick(1);  check_digit("wrapld.d0new", 4'b1110, G_5, 1'b1);

    // Reset mid-scan wins over a simultaneous load.
    tick(5);
    rst = 1'b1; digits_in = 16'h7777; blank_in = 4'b0000; load = 1'b1;
    tick(1);
    check_digit("rstmid", 4'b1111, G_DARK, 1'b1);
    check_val("rstmid.fd", 32'(frame_done), 32'd0);
    rst = 1'b0; load = 1'b0;
    tick(1);  check_digit("rstrel.d0", 4'b1110, G_DARK, 1'b1);
    wait_fd("rstrel.wrap");
    tick(1);  check_digit("rstrel.noload", 4'b1110, G_DARK, 1'b1);

    do_load(16'h8888, 4'b0000, 4'b0000, 4'b1000);
    wait_fd("blink.first");
    vis_pat = BLINK_BUILT ? 6'b001100 : 6'b111111;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check_digit($sformatf("blink%0d.d0", k), 4'b1110, G_8, 1'b1);
      tick(12);
      check_digit($sformatf("blink%0d.d3", k), 4'b0111, vis_pat[5-k] ? G_8 : G_DARK, 1'b1);
      wait_fd($sformatf("blink%0d.wrap", k));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
